// File: rtl/expand_vector_unit_if.sv
// ============================================================================
//  Module      : expand_vector_unit_if
//  Description : Control/handshake bundle for the expand vector unit:
//                mode select, start, seed scalars, input stream handshake,
//                output enable and status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface expand_vector_unit_if #(
    parameter int BITS = 8
);
    logic [1:0]      sel;
    logic            start;
    logic [BITS-1:0] scalar;
    logic [BITS-1:0] step;
    logic [BITS-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic            en;
    logic            busy;
    logic            done;

    // Host / sequencer side
    modport master (
        output sel, start, scalar, step, in_data, in_valid, en,
        input  in_ready, busy, done
    );

    // Unit side
    modport slave (
        input  sel, start, scalar, step, in_data, in_valid, en,
        output in_ready, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/expand_vector_unit.sv
// ============================================================================
//  Module      : expand_vector_unit
//  Description : Builds an N-element signed vector serially in one of four
//                modes (broadcast, ramp, stream load, prefix scan). The
//                result register drives the vector bus through a tri-state
//                gated by en.
//                Optional macro EXPAND_VECTOR_SATURATE_EN: ramp/scan adds
//                saturate instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module expand_vector_unit #(
    parameter int BITS = 8,
    parameter int N    = 64
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    expand_vector_unit_if.slave            bus,
    output wire logic [N-1:0][BITS-1:0]    out
);

    localparam int            IW     = $clog2(N);
    localparam logic [IW:0]   c_LAST = (IW+1)'(N-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [N-1:0][BITS-1:0]  r_vec;
    logic [IW:0]             r_idx;
    logic [BITS-1:0]         r_acc;
    logic [1:0]              r_sel;
    logic [BITS-1:0]         r_scalar;
    logic [BITS-1:0]         r_step;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_in_ready;

    logic [BITS-1:0]         w_sum;
    logic [BITS-1:0]         w_elem;
    logic [BITS-1:0]         w_acc_next;
    logic                    w_beat;

    // Two's complement add; the saturating variant clamps on signed overflow
    function automatic logic [BITS-1:0] f_add(input logic [BITS-1:0] a,
                                              input logic [BITS-1:0] b);
`ifdef EXPAND_VECTOR_SATURATE_EN
        logic [BITS:0] s;
        s = {a[BITS-1], a} + {b[BITS-1], b};
        if (s[BITS] != s[BITS-1])
            f_add = s[BITS] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
        else
            f_add = s[BITS-1:0];
`else
        f_add = a + b;
`endif
    endfunction

    // Element value and accumulator update for the current fill cycle
    always_comb begin
        w_sum      = f_add(r_acc, bus.in_data);
        w_elem     = r_scalar;
        w_acc_next = r_acc;
        case (r_sel)
            2'b00: w_elem = r_scalar;
            2'b01: begin
                w_elem     = r_acc;
                w_acc_next = f_add(r_acc, r_step);
            end
            2'b10: w_elem = bus.in_data;
            default: begin
                w_elem     = w_sum;
                w_acc_next = w_sum;
            end
        endcase
        // Generated modes write every cycle; stream modes only on accepted beats
        w_beat = r_sel[1] ? bus.in_valid : 1'b1;
    end

    // Sequencer FSM with registered status outputs and the vector register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_vec      <= '0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_sel      <= 2'b00;
            r_scalar   <= '0;
            r_step     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state    <= S_FILL;
                        r_sel      <= bus.sel;
                        r_scalar   <= bus.scalar;
                        r_step     <= bus.step;
                        r_idx      <= '0;
                        r_acc      <= (bus.sel == 2'b01) ? bus.scalar : '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_in_ready <= bus.sel[1];
                    end
                end
                S_FILL: begin
                    if (w_beat) begin
                        r_vec[r_idx[IW-1:0]] <= w_elem;
                        r_acc                <= w_acc_next;
                        r_idx                <= r_idx + 1'b1;
                        if (r_idx == c_LAST) begin
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.in_ready = r_in_ready;

    // Output enable only gates the bus; the register is untouched
    assign out = bus.en ? r_vec : {N{{BITS{1'bz}}}};

endmodule

`default_nettype wire
